// File: rtl/r5p_soc_tcb_arbiter.sv
// Two-requester TCB-Lite arbiter sharing one DLY=1 subordinate.
// Round-robin or fixed-priority grant, held across stalls and locked sequences.
module r5p_soc_tcb_arbiter #(
    parameter int unsigned ADR = 32,
    parameter int unsigned DAT = 32,
    parameter bit          PRI = 1'b0
)(
    input  logic           clk,
    input  logic           rst,
    // requester 0
    input  logic           s0_vld,
    input  logic           s0_lck,
    input  logic           s0_ren,
    input  logic           s0_wen,
    input  logic [ADR-1:0] s0_adr,
    input  logic [1:0]     s0_siz,
    input  logic [DAT-1:0] s0_wdt,
    output logic [DAT-1:0] s0_rdt,
    output logic           s0_err,
    output logic           s0_rdy,
    // requester 1
    input  logic           s1_vld,
    input  logic           s1_lck,
    input  logic           s1_ren,
    input  logic           s1_wen,
    input  logic [ADR-1:0] s1_adr,
    input  logic [1:0]     s1_siz,
    input  logic [DAT-1:0] s1_wdt,
    output logic [DAT-1:0] s1_rdt,
    output logic           s1_err,
    output logic           s1_rdy,
    // shared subordinate
    output logic           m_vld,
    output logic           m_lck,
    output logic           m_ren,
    output logic           m_wen,
    output logic [ADR-1:0] m_adr,
    output logic [1:0]     m_siz,
    output logic [DAT-1:0] m_wdt,
    input  logic [DAT-1:0] m_rdt,
    input  logic           m_err,
    input  logic           m_rdy
);

    logic r_lst;      // last granted requester
    logic r_hld;      // grant held by a stalled request
    logic r_lck;      // grant held by a locked sequence
    logic r_own;      // owner while held or locked
    logic r_rsp_vld;  // a transfer happened last cycle
    logic r_rsp_sel;  // requester that issued last cycle's transfer

    logic w_gnt;
    logic w_trn;

    always_comb begin
        // NOTE: default first so every path assigns w_gnt and no latch is inferred.
        w_gnt = r_lst;
        if (r_hld || r_lck) begin
            w_gnt = r_own;
        end else if (s0_vld && !s1_vld) begin
            w_gnt = 1'b0;
        end else if (s1_vld && !s0_vld) begin
            w_gnt = 1'b1;
        end else if (s0_vld && s1_vld) begin
            w_gnt = PRI ? 1'b0 : ~r_lst;
        end
    end

    // Request path; reset suppresses any transfer so state and bus stay consistent.
    assign m_vld = ~rst & (w_gnt ? s1_vld : s0_vld);
    assign m_lck = ~rst & (w_gnt ? s1_lck : s0_lck);
    assign m_ren = w_gnt ? s1_ren : s0_ren;
    assign m_wen = w_gnt ? s1_wen : s0_wen;
    assign m_adr = w_gnt ? s1_adr : s0_adr;
    assign m_siz = w_gnt ? s1_siz : s0_siz;
    assign m_wdt = w_gnt ? s1_wdt : s0_wdt;

    assign w_trn = m_vld & m_rdy;

    assign s0_rdy = ~rst & m_rdy & ~w_gnt;
    assign s1_rdy = ~rst & m_rdy &  w_gnt;

    // Response is routed by the registered selector, not by the current grant.
    assign s0_rdt = m_rdt;
    assign s1_rdt = m_rdt;
    assign s0_err = ~rst & m_err & r_rsp_vld & ~r_rsp_sel;
    assign s1_err = ~rst & m_err & r_rsp_vld &  r_rsp_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep all state updates race-free within the edge.
            r_lst     <= 1'b1;
            r_hld     <= 1'b0;
            r_lck     <= 1'b0;
            r_own     <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_rsp_sel <= 1'b0;
        end else begin
            r_rsp_vld <= w_trn;
            r_rsp_sel <= w_gnt;
            if (w_trn) begin
                r_lst <= w_gnt;
                r_hld <= 1'b0;
                r_lck <= m_lck;
                if (m_lck) begin
                    r_own <= w_gnt;
                end
            end else if (m_vld && !m_rdy) begin
                r_hld <= 1'b1;
                r_own <= w_gnt;
            end
        end
    end

endmodule
